// File: rtl/sap_core_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sap_pkg
// Purpose  : Shared opcodes, FSM state type and instruction field helpers
//            for the parametrised SAP accumulator core.
// Revision : 1.0 - initial release
// ============================================================================
package sap_pkg;

  // Instruction opcodes (top four bits of the instruction word)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Widest instruction word the field helper accepts
  localparam int unsigned OPC_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  // Opcode sits in the top nibble of a data_w-bit word; callers zero-extend
  // their instruction register to OPC_MAX_W before passing it in.
  function automatic logic [3:0] opcode_of(input logic [OPC_MAX_W-1:0] word,
                                           input int unsigned           data_w);
    return 4'(word >> (data_w - 4));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sap_core_param_if.sv
`default_nettype none
// ============================================================================
// Module   : sap_core_param_if
// Purpose  : Program-load and observation bundle between the Tiny Tapeout
//            wrapper (master) and the SAP core (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface sap_core_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              prog;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              halted;
  logic [ADDR_W-1:0] pc_o;

  modport master (
    output prog, prog_we, prog_addr, prog_data,
    input  out_data, out_valid, halted, pc_o
  );

  modport slave (
    input  prog, prog_we, prog_addr, prog_data,
    output out_data, out_valid, halted, pc_o
  );
endinterface
`default_nettype wire

// File: rtl/sap_core_param_ram.sv
`default_nettype none
// ============================================================================
// Module   : sap_ram
// Purpose  : 2^ADDR_W x DATA_W unified program/data store, one synchronous
//            write port and one combinational read port (read-old on
//            same-address collision). Contents survive reset.
// Revision : 1.0 - initial release
// ============================================================================
module sap_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: no reset so program contents persist across core resets
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule
`default_nettype wire

// File: rtl/sap_core_param.sv
`default_nettype none
// ============================================================================
// Module   : sap_core_param
// Purpose  : Parametrised SAP-1 style accumulator CPU with carry/zero flags,
//            conditional jumps, immediate load and an output-valid strobe.
//            Fetch (T1), execute (T2), arithmetic write-back (T3).
// Revision : 1.0 - initial release
// ============================================================================
module sap_core_param
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  sap_core_param_if.slave bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ir_q, ir_d, out_q, out_d;
  logic              c_q, c_d, z_q, z_d, out_valid_q, out_valid_d;

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_operand;
  logic [DATA_W-1:0] w_imm, w_b_eff;
  logic              w_is_sub;
  logic [DATA_W:0]   w_sum;

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr, w_mem_raddr;
  logic [DATA_W-1:0] w_mem_wdata, w_mem_rdata;

  sap_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (w_mem_we),
    .waddr_i (w_mem_waddr),
    .wdata_i (w_mem_wdata),
    .raddr_i (w_mem_raddr),
    .rdata_o (w_mem_rdata)
  );

  assign w_opcode  = opcode_of(OPC_MAX_W'(ir_q), DATA_W);
  assign w_operand = ir_q[ADDR_W-1:0];
  assign w_imm     = {{(DATA_W-ADDR_W){1'b0}}, w_operand};

  // SUB is A + ~B + 1 so the carry out doubles as "no borrow"
  assign w_is_sub  = (w_opcode == OP_SUB);
  assign w_b_eff   = w_is_sub ? ~b_q : b_q;
  assign w_sum     = {1'b0, a_q} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, w_is_sub};

  // State and architectural registers; reset leaves memory untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_T1;
      pc_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ir_q        <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ir_q        <= ir_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, datapath updates and memory port muxing
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    a_d         = a_q;
    b_d         = b_q;
    ir_d        = ir_q;
    c_d         = c_q;
    z_d         = z_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_waddr = bus.prog_addr;
    w_mem_wdata = bus.prog_data;
    w_mem_raddr = pc_q;

    if (bus.prog) begin
      // Program mode wins over everything: the in-flight instruction is
      // dropped and only the loader may touch memory.
      state_d  = ST_LOAD;
      w_mem_we = bus.prog_we;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          state_d = ST_T1;
          pc_d    = '0;
          a_d     = '0;
          b_d     = '0;
          ir_d    = '0;
          c_d     = 1'b0;
          z_d     = 1'b0;
          out_d   = '0;
        end
        ST_T1: begin
          ir_d    = w_mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_T2;
        end
        ST_T2: begin
          w_mem_raddr = w_operand;
          state_d     = ST_T3;
          unique case (w_opcode)
            OP_LDA:         a_d = w_mem_rdata;
            OP_ADD, OP_SUB: b_d = w_mem_rdata;
            OP_STA: begin
              w_mem_we    = 1'b1;
              w_mem_waddr = w_operand;
              w_mem_wdata = a_q;
            end
            OP_LDI:         a_d = w_imm;
            OP_JMP:         pc_d = w_operand;
            OP_JC:          if (c_q) pc_d = w_operand;
            OP_JZ:          if (z_q) pc_d = w_operand;
            OP_OUT: begin
              out_d       = a_q;
              out_valid_d = 1'b1;
            end
            OP_HLT:         state_d = ST_HALT;
            default: ;
          endcase
        end
        ST_T3: begin
          state_d = ST_T1;
          if ((w_opcode == OP_ADD) || (w_opcode == OP_SUB)) begin
            a_d = w_sum[DATA_W-1:0];
            c_d = w_sum[DATA_W];
            z_d = (w_sum[DATA_W-1:0] == '0);
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_T1;
      endcase
    end
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.halted    = (state_q == ST_HALT);
  assign bus.pc_o      = pc_q;
endmodule
`default_nettype wire

// File: tb/tb_sap_core_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sap_core_param
// Purpose  : Self-checking bench for sap_core_param at 8/4 and 12/6 widths.
//            An instruction-level interpreter predicts the per-cycle outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sap_core_param;

  typedef struct {
    int pc;
    int out;
    int valid;
    int halted;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sap_core_param_if #(.DATA_W(8),  .ADDR_W(4)) bus8 ();
  sap_core_param_if #(.DATA_W(12), .ADDR_W(6)) bus12 ();

  sap_core_param #(.DATA_W(8), .ADDR_W(4)) u_dut8 (
    .clk (clk), .reset (reset), .bus (bus8.slave)
  );
  sap_core_param #(.DATA_W(12), .ADDR_W(6)) u_dut12 (
    .clk (clk), .reset (reset), .bus (bus12.slave)
  );

  exp_t exp_q[$];
  int   img[64];
  int   sel;
  bit   chk_active;
  int   n_cmp, n_fail, trace_idx;

  // Instruction-level interpreter: each instruction yields its T1, T2 and
  // T3 cycles; HLT yields T1, T2 and then halted cycles.
  function automatic void build_trace(input int dw, input int aw, input int ncyc);
    int m[64];
    int pc, a, c, z, outv, npc, ir, opc, op, v, sum, mask, amask, valid;
    mask  = (1 << dw) - 1;
    amask = (1 << aw) - 1;
    for (int i = 0; i < 64; i++) m[i] = img[i];
    pc = 0; a = 0; c = 0; z = 0; outv = 0;
    exp_q.delete();
    while (exp_q.size() < ncyc) begin
      ir    = m[pc];
      opc   = (ir >> (dw - 4)) & 15;
      op    = ir & amask;
      npc   = (pc + 1) & amask;
      valid = 0;
      exp_q.push_back('{pc, outv, 0, 0});
      exp_q.push_back('{npc, outv, 0, 0});
      if (opc == 15) begin
        while (exp_q.size() < ncyc) exp_q.push_back('{npc, outv, 0, 1});
      end else begin
        v = m[op];
        case (opc)
          1: a = v;
          2, 3: begin
            sum = (opc == 2) ? (a + v) : (a + ((~v) & mask) + 1);
            c   = (sum >> dw) & 1;
            a   = sum & mask;
            z   = (a == 0) ? 1 : 0;
          end
          4: m[op] = a;
          5: a = op;
          6: npc = op;
          7: if (c != 0) npc = op;
          8: if (z != 0) npc = op;
          14: begin outv = a; valid = 1; end
          default: ;
        endcase
        exp_q.push_back('{npc, outv, valid, 0});
        pc = npc;
      end
    end
    while (exp_q.size() > ncyc) void'(exp_q.pop_back());
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Per-cycle comparison of the selected DUT against the predicted trace
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] apc, aout, av, ah;
    if (chk_active && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (sel == 0) begin
        apc = 32'(bus8.pc_o);  aout = 32'(bus8.out_data);
        av  = 32'(bus8.out_valid); ah = 32'(bus8.halted);
      end else begin
        apc = 32'(bus12.pc_o); aout = 32'(bus12.out_data);
        av  = 32'(bus12.out_valid); ah = 32'(bus12.halted);
      end
      n_cmp++;
      if (apc !== e.pc || aout !== e.out || av !== e.valid || ah !== e.halted) begin
        n_fail++;
        $display("FAIL trace[%0d] dut%0d pc/out/valid/halted: got %0h/%0h/%0h/%0h, expected %0h/%0h/%0h/%0h",
                 trace_idx, sel, apc, aout, av, ah, e.pc, e.out, e.valid, e.halted);
      end
      trace_idx++;
    end
  end

  task automatic set_prog(input int s, input logic v);
    if (s == 0) bus8.prog = v; else bus12.prog = v;
  endtask

  task automatic enter_load(input int s);
    set_prog(s, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 0;
  endtask

  task automatic load_image(input int s);
    int depth;
    depth = (s == 0) ? 16 : 64;
    enter_load(s);
    for (int i = 0; i < depth; i++) begin
      if (s == 0) begin
        bus8.prog_we = 1'b1; bus8.prog_addr = 4'(i); bus8.prog_data = 8'(img[i]);
      end else begin
        bus12.prog_we = 1'b1; bus12.prog_addr = 6'(i); bus12.prog_data = 12'(img[i]);
      end
      @(negedge clk);
    end
    bus8.prog_we  = 1'b0;
    bus12.prog_we = 1'b0;
  endtask

  // Release program mode; the trace starts with the first T1 cycle
  task automatic start_run(input int s);
    sel       = s;
    trace_idx = 0;
    @(negedge clk);
    set_prog(s, 1'b0);
    @(posedge clk);
    chk_active = 1'b1;
  endtask

  task automatic finish_run(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("run_complete_entries_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk_active = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0; sel = 0; chk_active = 1'b0; trace_idx = 0;
    reset = 1'b0;
    bus8.prog  = 1'b1; bus8.prog_we  = 1'b0; bus8.prog_addr  = '0; bus8.prog_data  = '0;
    bus12.prog = 1'b1; bus12.prog_we = 1'b0; bus12.prog_addr = '0; bus12.prog_data = '0;
    #3 reset = 1'b1;
    #20;
    check("reset_pc",        32'(bus8.pc_o),      0);
    check("reset_out_data",  32'(bus8.out_data),  0);
    check("reset_out_valid", 32'(bus8.out_valid), 0);
    check("reset_halted",    32'(bus8.halted),    0);
    check("reset_pc_w12",    32'(bus12.pc_o),     0);
    @(negedge clk);
    reset = 1'b0;

    // Basic add and output
    clear_img();
    img[0] = 'h1E; img[1] = 'h2F; img[2] = 'hE0; img[3] = 'hF0;
    img[14] = 'h1C; img[15] = 'h0E;
    load_image(0);
    build_trace(8, 4, 14);
    check("model_t1_out",       32'(exp_q[8].out),     'h2A);
    check("model_t1_valid",     32'(exp_q[8].valid),   1);
    check("model_t1_valid_end", 32'(exp_q[9].valid),   0);
    check("model_t1_halt_pre",  32'(exp_q[10].halted), 0);
    check("model_t1_halt",      32'(exp_q[11].halted), 1);
    start_run(0);
    finish_run(40);

    // Partial rerun, then asynchronous reset after OUT has fired
    enter_load(0);
    build_trace(8, 4, 10);
    start_run(0);
    finish_run(40);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_pc",    32'(bus8.pc_o),      0);
    check("async_reset_out",   32'(bus8.out_data),  0);
    check("async_reset_valid", 32'(bus8.out_valid), 0);
    check("async_reset_halt",  32'(bus8.halted),    0);
    @(posedge clk);
    #1 reset = 1'b0;
    build_trace(8, 4, 14);
    sel = 0; trace_idx = 0; chk_active = 1'b1;
    finish_run(40);

    // Carry and JC, then JZ not taken
    clear_img();
    img[0] = 'h1E; img[1] = 'h2F; img[2] = 'h75; img[3] = 'h50; img[4] = 'hF0;
    img[5] = 'hE0; img[6] = 'h84; img[7] = 'hF0; img[14] = 'hF0; img[15] = 'h20;
    load_image(0);
    build_trace(8, 4, 19);
    check("model_jc_taken", 32'(exp_q[8].pc),   5);
    check("model_jc_out",   32'(exp_q[11].out), 'h10);
    check("model_jz_not",   32'(exp_q[14].pc),  7);
    start_run(0);
    finish_run(50);

    // Subtract to zero: JZ and JC both taken
    clear_img();
    img[0] = 'h1E; img[1] = 'h3F; img[2] = 'h86; img[3] = 'hE0; img[4] = 'h76;
    img[5] = 'hF0; img[6] = 'h78; img[7] = 'hF0; img[8] = 'hE0; img[9] = 'hF0;
    img[14] = 'h05; img[15] = 'h05;
    load_image(0);
    build_trace(8, 4, 19);
    check("model_jz_taken",  32'(exp_q[8].pc),     6);
    check("model_jc_nb",     32'(exp_q[11].pc),    8);
    check("model_zero_out",  32'(exp_q[14].valid), 1);
    check("model_zero_halt", 32'(exp_q[17].pc),    10);
    start_run(0);
    finish_run(50);

    // Subtract with borrow: A=0xFF, neither jump taken
    img[15] = 'h06;
    load_image(0);
    build_trace(8, 4, 19);
    check("model_borrow_out", 32'(exp_q[11].out), 'hFF);
    check("model_jc_not",     32'(exp_q[14].pc),  5);
    start_run(0);
    finish_run(50);

    // STA / LDA round trip through memory
    clear_img();
    img[0] = 'h57; img[1] = 'h4D; img[2] = 'h1D; img[3] = 'hE0; img[4] = 'hF0;
    load_image(0);
    build_trace(8, 4, 16);
    check("model_sta_out", 32'(exp_q[11].out), 'h07);
    start_run(0);
    finish_run(40);

    // NOP-filled memory: PC wraps 15 -> 0
    clear_img();
    load_image(0);
    build_trace(8, 4, 54);
    check("model_wrap_pc15", 32'(exp_q[45].pc), 15);
    check("model_wrap_pc0",  32'(exp_q[46].pc), 0);
    start_run(0);
    finish_run(80);

    // Abort during T2 of an ADD, then restart from a clean state
    clear_img();
    img[0] = 'h2F; img[1] = 'h2F; img[2] = 'hE0; img[3] = 'hF0; img[15] = 'h05;
    load_image(0);
    build_trace(8, 4, 13);
    check("model_abort_prog_out", 32'(exp_q[8].out), 'h0A);
    start_run(0);
    finish_run(40);
    enter_load(0);
    build_trace(8, 4, 5);
    start_run(0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    chk_active = 1'b0;
    set_prog(0, 1'b1);
    check("abort_trace_left", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    check("abort_load_halted", 32'(bus8.halted),    0);
    check("abort_load_valid",  32'(bus8.out_valid), 0);
    @(posedge clk); #1;
    check("abort_load_halted2", 32'(bus8.halted), 0);
    build_trace(8, 4, 13);
    start_run(0);
    finish_run(40);

    // 12-bit data / 6-bit address instance
    set_prog(0, 1'b1);
    clear_img();
    img[0] = 'h13E; img[1] = 'hE00; img[2] = 'h23F; img[3] = 'h805; img[4] = 'hF00;
    img[5] = 'h707; img[6] = 'hF00; img[7] = 'hE00; img[8] = 'hF00;
    img[62] = 'hFFF; img[63] = 'h001;
    load_image(1);
    build_trace(12, 6, 22);
    check("model_w12_first_out", 32'(exp_q[5].out),     'hFFF);
    check("model_w12_jz",        32'(exp_q[11].pc),     5);
    check("model_w12_zero_out",  32'(exp_q[17].out),    0);
    check("model_w12_valid",     32'(exp_q[17].valid),  1);
    check("model_w12_halt",      32'(exp_q[20].halted), 1);
    start_run(1);
    finish_run(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
